// File: rtl/brq_pkg.sv
// Shared types for the BRQ memory arbiter.
// Source IDs and the round-robin pick used by the arbiter.
package brq_pkg;

   typedef enum logic {
      ArbSrcInstr = 1'b0,
      ArbSrcData  = 1'b1
   } arb_src_e;

   localparam logic [3:0]  InstrBe    = 4'hF;
   localparam logic [31:0] InstrWdata = 32'h0;

   // Lone requester wins; on a tie the source not granted last time wins.
   function automatic arb_src_e arb_pick(
      input logic     instr_req,
      input logic     data_req,
      input arb_src_e last_src
   );
      arb_src_e pick;
      pick = ArbSrcInstr;
      unique case ({instr_req, data_req})
         2'b01:   pick = ArbSrcData;
         2'b11:   pick = (last_src == ArbSrcInstr) ? ArbSrcData : ArbSrcInstr;
         default: pick = ArbSrcInstr;
      endcase
      return pick;
   endfunction

endpackage

// File: rtl/brq_arb_id_fifo.sv
// In-order FIFO of 1-bit source IDs for outstanding requests.
// A pop never frees a slot for a push in the same cycle.
module brq_arb_id_fifo #(
   parameter int unsigned Depth = 2
) (
   input  logic clk_i,
   input  logic rst_ni,
   input  logic push_i,
   input  logic push_id_i,
   input  logic pop_i,
   output logic full_o,
   output logic empty_o,
   output logic head_o
);

   localparam int unsigned PtrW = (Depth > 1) ? $clog2(Depth) : 1;
   localparam int unsigned CntW = $clog2(Depth + 1);
   localparam logic [PtrW-1:0] LastPtr = PtrW'(Depth - 1);

   logic [Depth-1:0] mem_q;
   logic [PtrW-1:0]  wr_ptr_q;
   logic [PtrW-1:0]  rd_ptr_q;
   logic [CntW-1:0]  count_q;
   logic             push_ok;
   logic             pop_ok;

   function automatic logic [PtrW-1:0] ptr_inc(input logic [PtrW-1:0] p);
      return (p == LastPtr) ? '0 : p + 1'b1;
   endfunction

   assign full_o  = (count_q == CntW'(Depth));
   assign empty_o = (count_q == '0);
   assign head_o  = mem_q[rd_ptr_q];
   assign push_ok = push_i & ~full_o;
   assign pop_ok  = pop_i & ~empty_o;

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         mem_q    <= '0;
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         if (push_ok) begin
            mem_q[wr_ptr_q] <= push_id_i;
            wr_ptr_q        <= ptr_inc(wr_ptr_q);
         end
         if (pop_ok) begin
            rd_ptr_q <= ptr_inc(rd_ptr_q);
         end
         unique case ({push_ok, pop_ok})
            2'b10:   count_q <= count_q + CntW'(1);
            2'b01:   count_q <= count_q - CntW'(1);
            default: count_q <= count_q;
         endcase
      end
   end

endmodule

// File: rtl/brq_mem_arbiter.sv
// Round-robin arbiter merging core fetch and LSU ports onto one bus.
// Responses return in order and are routed by an ID FIFO.
module brq_mem_arbiter
   import brq_pkg::*;
#(
   parameter int unsigned MaxOutstanding = 2
) (
   input  logic        clk_i,
   input  logic        rst_ni,

   input  logic        instr_req_i,
   input  logic [31:0] instr_addr_i,
   output logic        instr_gnt_o,
   output logic        instr_rvalid_o,
   output logic [31:0] instr_rdata_o,
   output logic        instr_err_o,

   input  logic        data_req_i,
   input  logic        data_we_i,
   input  logic [3:0]  data_be_i,
   input  logic [31:0] data_addr_i,
   input  logic [31:0] data_wdata_i,
   output logic        data_gnt_o,
   output logic        data_rvalid_o,
   output logic [31:0] data_rdata_o,
   output logic        data_err_o,

   output logic        req_o,
   output logic [31:0] addr_o,
   output logic        we_o,
   output logic [3:0]  be_o,
   output logic [31:0] wdata_o,
   input  logic        gnt_i,
   input  logic        rvalid_i,
   input  logic [31:0] rdata_i,
   input  logic        err_i,

   output logic        unexp_rsp_o
);

   arb_src_e last_q;
   arb_src_e lock_src_q;
   arb_src_e sel_src;
   arb_src_e head_src;
   logic     lock_q;
   logic     lock_live;
   logic     unexp_q;
   logic     fifo_full;
   logic     fifo_empty;
   logic     fifo_head;
   logic     fire;
   logic     pop;

   // A stalled request keeps its source until the bus accepts it.
   assign lock_live = lock_q & ((lock_src_q == ArbSrcInstr) ? instr_req_i
                                                           : data_req_i);
   assign sel_src   = lock_live ? lock_src_q
                                : arb_pick(instr_req_i, data_req_i, last_q);

   assign req_o = (instr_req_i | data_req_i) & ~fifo_full;
   assign fire  = req_o & gnt_i;

   always_comb begin
      addr_o  = instr_addr_i;
      we_o    = 1'b0;
      be_o    = InstrBe;
      wdata_o = InstrWdata;
      unique case (sel_src)
         ArbSrcData: begin
            addr_o  = data_addr_i;
            we_o    = data_we_i;
            be_o    = data_be_i;
            wdata_o = data_wdata_i;
         end
         default: begin
            addr_o  = instr_addr_i;
            we_o    = 1'b0;
            be_o    = InstrBe;
            wdata_o = InstrWdata;
         end
      endcase
   end

   assign instr_gnt_o = fire & (sel_src == ArbSrcInstr);
   assign data_gnt_o  = fire & (sel_src == ArbSrcData);

   assign pop      = rvalid_i & ~fifo_empty;
   assign head_src = arb_src_e'(fifo_head);

   assign instr_rvalid_o = pop & (head_src == ArbSrcInstr);
   assign data_rvalid_o  = pop & (head_src == ArbSrcData);
   assign instr_rdata_o  = rdata_i;
   assign data_rdata_o   = rdata_i;
   assign instr_err_o    = err_i;
   assign data_err_o     = err_i;
   assign unexp_rsp_o    = unexp_q;

   brq_arb_id_fifo #(
      .Depth (MaxOutstanding)
   ) u_id_fifo (
      .clk_i     (clk_i),
      .rst_ni    (rst_ni),
      .push_i    (fire),
      .push_id_i (sel_src),
      .pop_i     (pop),
      .full_o    (fifo_full),
      .empty_o   (fifo_empty),
      .head_o    (fifo_head)
   );

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         last_q     <= ArbSrcData;
         lock_q     <= 1'b0;
         lock_src_q <= ArbSrcInstr;
         unexp_q    <= 1'b0;
      end else begin
         lock_q     <= req_o & ~gnt_i;
         lock_src_q <= sel_src;
         if (fire) begin
            last_q <= sel_src;
         end
         if (rvalid_i && fifo_empty) begin
            unexp_q <= 1'b1;
         end
      end
   end

endmodule

// File: tb/tb_brq_mem_arbiter.sv
// Vector-table bench for brq_mem_arbiter.
// Response routing is predicted by a queue of expected grant sources.
module tb_brq_mem_arbiter;
   import brq_pkg::*;

   localparam logic [31:0] DWdata = 32'hCAFE_F00D;

   logic        clk;
   logic        rst_ni;
   logic        instr_req_i;
   logic [31:0] instr_addr_i;
   logic        instr_gnt_o;
   logic        instr_rvalid_o;
   logic [31:0] instr_rdata_o;
   logic        instr_err_o;
   logic        data_req_i;
   logic        data_we_i;
   logic [3:0]  data_be_i;
   logic [31:0] data_addr_i;
   logic [31:0] data_wdata_i;
   logic        data_gnt_o;
   logic        data_rvalid_o;
   logic [31:0] data_rdata_o;
   logic        data_err_o;
   logic        req_o;
   logic [31:0] addr_o;
   logic        we_o;
   logic [3:0]  be_o;
   logic [31:0] wdata_o;
   logic        gnt_i;
   logic        rvalid_i;
   logic [31:0] rdata_i;
   logic        err_i;
   logic        unexp_rsp_o;

   brq_mem_arbiter #(.MaxOutstanding(2)) dut (
      .clk_i          (clk),
      .rst_ni         (rst_ni),
      .instr_req_i    (instr_req_i),
      .instr_addr_i   (instr_addr_i),
      .instr_gnt_o    (instr_gnt_o),
      .instr_rvalid_o (instr_rvalid_o),
      .instr_rdata_o  (instr_rdata_o),
      .instr_err_o    (instr_err_o),
      .data_req_i     (data_req_i),
      .data_we_i      (data_we_i),
      .data_be_i      (data_be_i),
      .data_addr_i    (data_addr_i),
      .data_wdata_i   (data_wdata_i),
      .data_gnt_o     (data_gnt_o),
      .data_rvalid_o  (data_rvalid_o),
      .data_rdata_o   (data_rdata_o),
      .data_err_o     (data_err_o),
      .req_o          (req_o),
      .addr_o         (addr_o),
      .we_o           (we_o),
      .be_o           (be_o),
      .wdata_o        (wdata_o),
      .gnt_i          (gnt_i),
      .rvalid_i       (rvalid_i),
      .rdata_i        (rdata_i),
      .err_i          (err_i),
      .unexp_rsp_o    (unexp_rsp_o)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      bit          rst;
      bit          irq;
      bit          drq;
      bit          dwe;
      logic [3:0]  dbe;
      logic [31:0] iaddr;
      logic [31:0] daddr;
      bit          gnt;
      bit          rv;
      logic [31:0] rdata;
      bit          err;
      bit          exp_req;
      bit          exp_ig;
      bit          exp_dg;
      arb_src_e    exp_win;
      logic [31:0] exp_addr;
      logic [3:0]  exp_be;
      bit          exp_we;
   } vec_t;

   vec_t     vecs[$];
   arb_src_e sb[$];
   bit       model_unexp;
   int       n_chk;
   int       n_fail;

   task automatic chk(input string name, input logic [31:0] act,
                      input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic idle_inputs();
      instr_req_i  = 1'b0;
      instr_addr_i = '0;
      data_req_i   = 1'b0;
      data_we_i    = 1'b0;
      data_be_i    = '0;
      data_addr_i  = '0;
      data_wdata_i = DWdata;
      gnt_i        = 1'b0;
      rvalid_i     = 1'b0;
      rdata_i      = '0;
      err_i        = 1'b0;
   endtask

   task automatic do_reset();
      @(negedge clk);
      rst_ni = 1'b0;
      idle_inputs();
      repeat (2) @(posedge clk);
      @(negedge clk);
      rst_ni = 1'b1;
      sb.delete();
      model_unexp = 1'b0;
   endtask

   function automatic vec_t v(
      input bit rst, input bit irq, input bit drq, input bit dwe,
      input logic [3:0] dbe, input logic [31:0] iaddr,
      input logic [31:0] daddr, input bit gnt, input bit rv,
      input logic [31:0] rdata, input bit err, input bit exp_req,
      input bit exp_ig, input bit exp_dg, input arb_src_e exp_win,
      input logic [31:0] exp_addr, input logic [3:0] exp_be,
      input bit exp_we);
      vec_t r;
      r.rst = rst; r.irq = irq; r.drq = drq; r.dwe = dwe;
      r.dbe = dbe; r.iaddr = iaddr; r.daddr = daddr; r.gnt = gnt;
      r.rv = rv; r.rdata = rdata; r.err = err; r.exp_req = exp_req;
      r.exp_ig = exp_ig; r.exp_dg = exp_dg; r.exp_win = exp_win;
      r.exp_addr = exp_addr; r.exp_be = exp_be; r.exp_we = exp_we;
      return r;
   endfunction

   task automatic apply(input vec_t t, input int idx);
      bit       rv_i;
      bit       rv_d;
      arb_src_e hd;
      string    tag;
      tag = $sformatf("v%0d", idx);
      if (t.rst) do_reset();
      @(posedge clk);
      #1;
      instr_req_i  = t.irq;
      instr_addr_i = t.iaddr;
      data_req_i   = t.drq;
      data_we_i    = t.dwe;
      data_be_i    = t.dbe;
      data_addr_i  = t.daddr;
      gnt_i        = t.gnt;
      rvalid_i     = t.rv;
      rdata_i      = t.rdata;
      err_i        = t.err;
      @(negedge clk);
      rv_i = 1'b0;
      rv_d = 1'b0;
      if (t.rv && sb.size() > 0) begin
         hd = sb.pop_front();
         rv_i = (hd == ArbSrcInstr);
         rv_d = (hd == ArbSrcData);
      end
      chk({tag, " req_o"}, 32'(req_o), 32'(t.exp_req));
      chk({tag, " instr_gnt"}, 32'(instr_gnt_o), 32'(t.exp_ig));
      chk({tag, " data_gnt"}, 32'(data_gnt_o), 32'(t.exp_dg));
      if (t.exp_req) begin
         chk({tag, " addr_o"}, addr_o, t.exp_addr);
         chk({tag, " be_o"}, 32'(be_o), 32'(t.exp_be));
         chk({tag, " we_o"}, 32'(we_o), 32'(t.exp_we));
         chk({tag, " wdata_o"}, wdata_o,
             (t.exp_win == ArbSrcData) ? DWdata : 32'h0);
      end
      chk({tag, " instr_rvalid"}, 32'(instr_rvalid_o), 32'(rv_i));
      chk({tag, " data_rvalid"}, 32'(data_rvalid_o), 32'(rv_d));
      chk({tag, " unexp_rsp"}, 32'(unexp_rsp_o), 32'(model_unexp));
      if (t.rv) begin
         chk({tag, " instr_rdata"}, instr_rdata_o, t.rdata);
         chk({tag, " data_rdata"}, data_rdata_o, t.rdata);
         chk({tag, " instr_err"}, 32'(instr_err_o), 32'(t.err));
         chk({tag, " data_err"}, 32'(data_err_o), 32'(t.err));
      end
      if (t.rv && !rv_i && !rv_d) model_unexp = 1'b1;
      if (t.exp_ig || t.exp_dg) sb.push_back(t.exp_win);
   endtask

   initial begin
      n_chk  = 0;
      n_fail = 0;
      rst_ni = 1'b1;
      model_unexp = 1'b0;
      idle_inputs();

      // single instr fetch, response next cycle
      vecs.push_back(v(1,0,0,0,4'h0,0,0,0,0,0,0, 0,0,0,ArbSrcInstr,0,4'h0,0));
      vecs.push_back(v(0,1,0,0,4'h0,32'h80,0,1,0,0,0,
                       1,1,0,ArbSrcInstr,32'h80,4'hF,0));
      vecs.push_back(v(0,0,0,0,4'h0,0,0,0,1,32'h13,0,
                       0,0,0,ArbSrcInstr,0,4'h0,0));
      // round robin, full stall with same-cycle response, err to data
      vecs.push_back(v(1,1,1,1,4'h5,32'h100,32'h2000,1,0,0,0,
                       1,1,0,ArbSrcInstr,32'h100,4'hF,0));
      vecs.push_back(v(0,1,1,1,4'h5,32'h100,32'h2000,1,0,0,0,
                       1,0,1,ArbSrcData,32'h2000,4'h5,1));
      vecs.push_back(v(0,1,1,1,4'h5,32'h100,32'h2000,1,1,32'h11,0,
                       0,0,0,ArbSrcInstr,0,4'h0,0));
      vecs.push_back(v(0,1,1,1,4'h5,32'h100,32'h2000,1,0,0,0,
                       1,1,0,ArbSrcInstr,32'h100,4'hF,0));
      vecs.push_back(v(0,0,0,0,4'h0,0,0,0,1,32'hBAD,1,
                       0,0,0,ArbSrcInstr,0,4'h0,0));
      vecs.push_back(v(0,0,0,0,4'h0,0,0,0,1,32'h22,0,
                       0,0,0,ArbSrcInstr,0,4'h0,0));
      vecs.push_back(v(0,0,0,0,4'h0,0,0,0,1,32'h44,0,
                       0,0,0,ArbSrcInstr,0,4'h0,0));
      vecs.push_back(v(0,0,0,0,4'h0,0,0,0,0,0,0, 0,0,0,ArbSrcInstr,0,4'h0,0));
      // stalled data write stays locked while instr_req rises
      vecs.push_back(v(1,0,1,1,4'h3,32'h80,32'h1000_0004,0,0,0,0,
                       1,0,0,ArbSrcData,32'h1000_0004,4'h3,1));
      vecs.push_back(v(0,1,1,1,4'h3,32'h80,32'h1000_0004,0,0,0,0,
                       1,0,0,ArbSrcData,32'h1000_0004,4'h3,1));
      vecs.push_back(v(0,1,1,1,4'h3,32'h80,32'h1000_0004,0,0,0,0,
                       1,0,0,ArbSrcData,32'h1000_0004,4'h3,1));
      vecs.push_back(v(0,1,1,1,4'h3,32'h80,32'h1000_0004,1,0,0,0,
                       1,0,1,ArbSrcData,32'h1000_0004,4'h3,1));
      vecs.push_back(v(0,1,1,1,4'h3,32'h80,32'h1000_0004,1,0,0,0,
                       1,1,0,ArbSrcInstr,32'h80,4'hF,0));
      vecs.push_back(v(0,0,0,0,4'h0,0,0,0,1,32'h33,0,
                       0,0,0,ArbSrcInstr,0,4'h0,0));
      vecs.push_back(v(0,0,0,0,4'h0,0,0,0,1,32'h55,0,
                       0,0,0,ArbSrcInstr,0,4'h0,0));
      // reset drops an outstanding ID; its late response is unexpected
      vecs.push_back(v(1,1,0,0,4'h0,32'h84,0,1,0,0,0,
                       1,1,0,ArbSrcInstr,32'h84,4'hF,0));
      vecs.push_back(v(1,0,0,0,4'h0,0,0,0,1,32'h66,0,
                       0,0,0,ArbSrcInstr,0,4'h0,0));
      vecs.push_back(v(0,0,0,0,4'h0,0,0,0,0,0,0, 0,0,0,ArbSrcInstr,0,4'h0,0));
      vecs.push_back(v(1,0,0,0,4'h0,0,0,0,0,0,0, 0,0,0,ArbSrcInstr,0,4'h0,0));

      foreach (vecs[i]) apply(vecs[i], i);

      // asynchronous reset clears the sticky flag without a clock edge
      @(posedge clk);
      #1;
      idle_inputs();
      rvalid_i = 1'b1;
      @(posedge clk);
      #1;
      rvalid_i = 1'b0;
      #2;
      chk("async unexp set", 32'(unexp_rsp_o), 32'h1);
      rst_ni = 1'b0;
      #1;
      chk("async unexp clear", 32'(unexp_rsp_o), 32'h0);
      chk("async req_o", 32'(req_o), 32'h0);
      @(negedge clk);
      rst_ni = 1'b1;
      sb.delete();
      model_unexp = 1'b0;
      repeat (2) @(posedge clk);

      $display("End of test - %0d assertions evaluated, %0d failures",
               n_chk, n_fail);
      $finish;
   end

endmodule
